// File: rtl/mem_stage_if.sv
// mem_stage_if: groups the EX->MEM pipeline inputs, the pipeline control
// (stall/flush) and every MEM-stage result into one bundle.
//   master modport : the upstream/observer side (drives *_in, stall, flush;
//                    reads the stage results).
//   slave modport  : the MEM stage itself.
//   Inputs : stall, flush, pc_in, instructure_in, instr_code_in,
//            alu_result_in, reg_read_data2_in
//   Outputs: pc_out, instructure_out, instr_code_out, alu_result_out,
//            mem_read_data_out, forward_data_MEM, addr_err, dm_we, dm_addr,
//            dm_wdata
interface mem_stage_if;
    logic        stall;
    logic        flush;
    logic [31:0] pc_in;
    logic [31:0] instructure_in;
    logic [5:0]  instr_code_in;
    logic [31:0] alu_result_in;
    logic [31:0] reg_read_data2_in;

    logic [31:0] pc_out;
    logic [31:0] instructure_out;
    logic [5:0]  instr_code_out;
    logic [31:0] alu_result_out;
    logic [31:0] mem_read_data_out;
    logic [31:0] forward_data_MEM;
    logic        addr_err;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;

    modport master (
        output stall, flush, pc_in, instructure_in, instr_code_in,
               alu_result_in, reg_read_data2_in,
        input  pc_out, instructure_out, instr_code_out, alu_result_out,
               mem_read_data_out, forward_data_MEM, addr_err, dm_we,
               dm_addr, dm_wdata
    );

    modport slave (
        input  stall, flush, pc_in, instructure_in, instr_code_in,
               alu_result_in, reg_read_data2_in,
        output pc_out, instructure_out, instr_code_out, alu_result_out,
               mem_read_data_out, forward_data_MEM, addr_err, dm_we,
               dm_addr, dm_wdata
    );
endinterface

// File: rtl/mem_stage.sv
// mem_stage: MEM stage of the 5-stage MIPS pipeline. Holds the EX/MEM
// pipeline register (reset > flush > stall > capture) and the word-organised
// data memory. Decodes lw/lh/lhu/lb/lbu/sw/sh/sb from the latched opcode,
// flags misaligned accesses, extends load data and merges sub-word stores.
//   clk   : rising-edge pipeline clock
//   reset : synchronous, active-high; clears the register and the memory
//   bus   : mem_stage_if.slave carrying stall/flush, the EX inputs and all
//           stage results (all results are combinational from the latched
//           fields and the memory)
module mem_stage #(
    parameter int DM_WORDS = 4096,
    parameter int DM_AW    = 12
) (
    input  logic        clk,
    input  logic        reset,
    mem_stage_if.slave  bus
);

    typedef enum logic [1:0] {
        SZ_NONE = 2'd0,
        SZ_BYTE = 2'd1,
        SZ_HALF = 2'd2,
        SZ_WORD = 2'd3
    } acc_size_e;

    // Sign- or zero-extends the low byte/halfword of raw according to size.
    function automatic logic [31:0] extend_load(input logic [31:0] raw,
                                                input acc_size_e sz,
                                                input logic sgn);
        logic [31:0] res;
        case (sz)
            SZ_BYTE: res = {{24{sgn & raw[7]}}, raw[7:0]};
            SZ_HALF: res = {{16{sgn & raw[15]}}, raw[15:0]};
            SZ_WORD: res = raw;
            default: res = 32'h0000_0000;
        endcase
        return res;
    endfunction

    logic [31:0] pc_r;
    logic [31:0] instr_r;
    logic [5:0]  code_r;
    logic [31:0] alu_r;
    logic [31:0] rt_r;
    logic [31:0] dm_r [DM_WORDS];

    logic            is_load_s;
    logic            is_store_s;
    logic            sign_s;
    acc_size_e       size_s;
    logic            misalign_s;
    logic [1:0]      lane_s;
    logic [DM_AW-1:0] widx_s;
    logic [31:0]     rd_word_s;
    logic [31:0]     raw_s;
    logic [31:0]     wdata_s;
    logic            we_s;

    // EX/MEM pipeline register: reset/flush insert a nop bubble, stall holds.
    always_ff @(posedge clk) begin
        if (reset || bus.flush) begin
            pc_r    <= 32'h0000_0000;
            instr_r <= 32'h0000_0000;
            code_r  <= 6'h00;
            alu_r   <= 32'h0000_0000;
            rt_r    <= 32'h0000_0000;
        end else if (bus.stall) begin
            pc_r    <= pc_r;
            instr_r <= instr_r;
            code_r  <= code_r;
            alu_r   <= alu_r;
            rt_r    <= rt_r;
        end else begin
            pc_r    <= bus.pc_in;
            instr_r <= bus.instructure_in;
            code_r  <= bus.instr_code_in;
            alu_r   <= bus.alu_result_in;
            rt_r    <= bus.reg_read_data2_in;
        end
    end

    // Access decode from the latched opcode field.
    always_comb begin
        is_load_s  = 1'b0;
        is_store_s = 1'b0;
        sign_s     = 1'b0;
        size_s     = SZ_NONE;
        case (instr_r[31:26])
            6'h23: begin is_load_s  = 1'b1; size_s = SZ_WORD; end
            6'h21: begin is_load_s  = 1'b1; size_s = SZ_HALF; sign_s = 1'b1; end
            6'h25: begin is_load_s  = 1'b1; size_s = SZ_HALF; end
            6'h20: begin is_load_s  = 1'b1; size_s = SZ_BYTE; sign_s = 1'b1; end
            6'h24: begin is_load_s  = 1'b1; size_s = SZ_BYTE; end
            6'h2B: begin is_store_s = 1'b1; size_s = SZ_WORD; end
            6'h29: begin is_store_s = 1'b1; size_s = SZ_HALF; end
            6'h28: begin is_store_s = 1'b1; size_s = SZ_BYTE; end
            default: begin
                is_load_s  = 1'b0;
                is_store_s = 1'b0;
            end
        endcase
    end

    // Alignment check; upper address bits beyond the memory are dropped so
    // accesses wrap modulo the memory size.
    always_comb begin
        lane_s = alu_r[1:0];
        widx_s = alu_r[DM_AW+1:2];
        case (size_s)
            SZ_WORD: misalign_s = (lane_s != 2'b00);
            SZ_HALF: misalign_s = lane_s[0];
            default: misalign_s = 1'b0;
        endcase
    end

    // Load path: pick the addressed lane, then extend.
    always_comb begin
        rd_word_s = dm_r[widx_s];
        case (size_s)
            SZ_BYTE: raw_s = {24'h00_0000, rd_word_s[{lane_s, 3'b000} +: 8]};
            SZ_HALF: raw_s = {16'h0000, rd_word_s[{lane_s[1], 4'b0000} +: 16]};
            SZ_WORD: raw_s = rd_word_s;
            default: raw_s = 32'h0000_0000;
        endcase
    end

    // Store path: overlay the store data on the current word contents.
    always_comb begin
        wdata_s = rd_word_s;
        case (size_s)
            SZ_BYTE: wdata_s[{lane_s, 3'b000} +: 8]    = rt_r[7:0];
            SZ_HALF: wdata_s[{lane_s[1], 4'b0000} +: 16] = rt_r[15:0];
            SZ_WORD: wdata_s = rt_r;
            default: wdata_s = rd_word_s;
        endcase
        we_s = is_store_s & ~misalign_s;
    end

    // Data memory: reset clears every word and overrides any pending store;
    // a stalled store simply rewrites the same merged word.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DM_WORDS; i++) begin
                dm_r[i] <= 32'h0000_0000;
            end
        end else if (we_s) begin
            dm_r[widx_s] <= wdata_s;
        end else begin
            dm_r[widx_s] <= dm_r[widx_s];
        end
    end

    assign bus.pc_out            = pc_r;
    assign bus.instructure_out   = instr_r;
    assign bus.instr_code_out    = code_r;
    assign bus.alu_result_out    = alu_r;
    assign bus.forward_data_MEM  = alu_r;
    assign bus.addr_err          = (is_load_s | is_store_s) & misalign_s;
    assign bus.dm_we             = we_s;
    assign bus.dm_addr           = {alu_r[31:2], 2'b00};
    assign bus.dm_wdata          = we_s ? wdata_s : 32'h0000_0000;
    assign bus.mem_read_data_out = (is_load_s && !misalign_s)
                                   ? extend_load(raw_s, size_s, sign_s)
                                   : 32'h0000_0000;

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed plus randomized bench for mem_stage. A byte-array
// reference model of the memory and a plain copy of the latched EX fields
// predict every output after each clock edge.
module tb_mem_stage;

    localparam logic [5:0] OP_LW = 6'h23, OP_LH = 6'h21, OP_LHU = 6'h25,
                           OP_LB = 6'h20, OP_LBU = 6'h24, OP_SW = 6'h2B,
                           OP_SH = 6'h29, OP_SB = 6'h28;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mem_stage_if bus();

    mem_stage #(.DM_WORDS(4096), .DM_AW(12)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_vec = 0;
    int n_miss = 0;

    // reference model state
    logic [7:0]  mb [16384];
    logic [31:0] m_pc, m_ins, m_alu, m_rt;
    logic [5:0]  m_code;

    logic [5:0] ops [8] = '{OP_LW, OP_LH, OP_LHU, OP_LB, OP_LBU, OP_SW, OP_SH, OP_SB};

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %08h expected %08h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] mk(input logic [5:0] op);
        logic [25:0] lo;
        lo = 26'($urandom());
        return {op, lo};
    endfunction

    // Predicts the memory-access results of the instruction held in the model.
    task automatic compute(output logic ld, output logic st, output logic mis,
                           output logic [31:0] rd, output logic [31:0] wd);
        int sz, ba, wb;
        logic sgn;
        logic [31:0] v;
        logic [7:0] b [4];
        ld = 1'b0; st = 1'b0; sgn = 1'b0; sz = 0;
        case (m_ins[31:26])
            OP_LW:  begin ld = 1'b1; sz = 4; end
            OP_LH:  begin ld = 1'b1; sz = 2; sgn = 1'b1; end
            OP_LHU: begin ld = 1'b1; sz = 2; end
            OP_LB:  begin ld = 1'b1; sz = 1; sgn = 1'b1; end
            OP_LBU: begin ld = 1'b1; sz = 1; end
            OP_SW:  begin st = 1'b1; sz = 4; end
            OP_SH:  begin st = 1'b1; sz = 2; end
            OP_SB:  begin st = 1'b1; sz = 1; end
            default: sz = 0;
        endcase
        ba  = int'(m_alu[13:0]);
        wb  = ba - (ba % 4);
        mis = (sz != 0) && ((ba % sz) != 0);
        rd  = 32'h0;
        wd  = 32'h0;
        if (ld && !mis) begin
            v = 32'h0;
            for (int i = 0; i < sz; i++) v = v | (32'(mb[ba + i]) << (8 * i));
            if (sgn) v = 32'($signed(v << (32 - 8 * sz)) >>> (32 - 8 * sz));
            rd = v;
        end
        if (st && !mis) begin
            for (int i = 0; i < 4; i++) b[i] = mb[wb + i];
            for (int i = 0; i < sz; i++) b[(ba % 4) + i] = m_rt[8 * i +: 8];
            wd = {b[3], b[2], b[1], b[0]};
        end
    endtask

    // Applies the effect of one rising edge to the model.
    task automatic model_edge(input logic rst, input logic stl, input logic fl,
                              input logic [31:0] pcv, input logic [31:0] ins,
                              input logic [5:0] codev, input logic [31:0] adr,
                              input logic [31:0] rt);
        logic ld, st, mis;
        logic [31:0] rd, wd;
        int wb;
        compute(ld, st, mis, rd, wd);
        if (rst) begin
            for (int i = 0; i < 16384; i++) mb[i] = 8'h00;
            m_pc = 32'h0; m_ins = 32'h0; m_code = 6'h0; m_alu = 32'h0; m_rt = 32'h0;
        end else begin
            if (st && !mis) begin
                wb = int'(m_alu[13:2]) * 4;
                for (int i = 0; i < 4; i++) mb[wb + i] = wd[8 * i +: 8];
            end
            if (fl) begin
                m_pc = 32'h0; m_ins = 32'h0; m_code = 6'h0; m_alu = 32'h0; m_rt = 32'h0;
            end else if (!stl) begin
                m_pc = pcv; m_ins = ins; m_code = codev; m_alu = adr; m_rt = rt;
            end
        end
    endtask

    task automatic check_all();
        logic ld, st, mis;
        logic [31:0] rd, wd;
        compute(ld, st, mis, rd, wd);
        check_val("pc_out",    bus.pc_out, m_pc);
        check_val("instr_out", bus.instructure_out, m_ins);
        check_val("code_out",  32'(bus.instr_code_out), 32'(m_code));
        check_val("alu_out",   bus.alu_result_out, m_alu);
        check_val("fwd_mem",   bus.forward_data_MEM, m_alu);
        check_val("rd_data",   bus.mem_read_data_out, rd);
        check_val("addr_err",  32'(bus.addr_err), 32'((ld || st) && mis));
        check_val("dm_we",     32'(bus.dm_we), 32'(st && !mis));
        check_val("dm_addr",   bus.dm_addr, {m_alu[31:2], 2'b00});
        check_val("dm_wdata",  bus.dm_wdata, wd);
    endtask

    // One clock cycle: drive inputs, advance the model at the edge, check at negedge.
    task automatic cyc(input logic rst, input logic stl, input logic fl,
                       input logic [31:0] ins, input logic [31:0] adr, input logic [31:0] rt);
        logic [31:0] pcv;
        logic [5:0]  codev;
        pcv   = $urandom();
        codev = 6'($urandom_range(0, 63));
        reset = rst;
        bus.stall = stl;
        bus.flush = fl;
        bus.pc_in = pcv;
        bus.instructure_in = ins;
        bus.instr_code_in = codev;
        bus.alu_result_in = adr;
        bus.reg_read_data2_in = rt;
        @(posedge clk);
        model_edge(rst, stl, fl, pcv, ins, codev, adr, rt);
        @(negedge clk);
        check_all();
    endtask

    initial begin
        logic [31:0] adr, ins;
        int r, k;
        for (int i = 0; i < 16384; i++) mb[i] = 8'h00;
        m_pc = 32'h0; m_ins = 32'h0; m_code = 6'h0; m_alu = 32'h0; m_rt = 32'h0;

        // reset, then a load of address 0
        cyc(1'b1, 1'b0, 1'b0, mk(OP_SW), 32'h10, 32'hFFFF_FFFF);
        cyc(1'b1, 1'b0, 1'b0, mk(OP_SW), 32'h10, 32'hFFFF_FFFF);
        check_val("rst_we", 32'(bus.dm_we), 32'h0);
        check_val("rst_pc", bus.pc_out, 32'h0);
        cyc(1'b0, 1'b0, 1'b0, mk(OP_LW), 32'h0, 32'h0);
        check_val("lw0", bus.mem_read_data_out, 32'h0);

        // word store then load
        cyc(1'b0, 1'b0, 1'b0, mk(OP_SW), 32'h10, 32'h1234_5678);
        check_val("sw_we", 32'(bus.dm_we), 32'h1);
        check_val("sw_wdata", bus.dm_wdata, 32'h1234_5678);
        cyc(1'b0, 1'b0, 1'b0, mk(OP_LW), 32'h10, 32'h0);
        check_val("lw10", bus.mem_read_data_out, 32'h1234_5678);

        // byte / halfword merge and extension
        cyc(1'b0, 1'b0, 1'b0, mk(OP_SB), 32'h11, 32'h55AA_CDAB);
        check_val("sb_wdata", bus.dm_wdata, 32'h1234_AB78);
        cyc(1'b0, 1'b0, 1'b0, mk(OP_SH), 32'h12, 32'h1234_BEEF);
        check_val("sh_wdata", bus.dm_wdata, 32'hBEEF_AB78);
        cyc(1'b0, 1'b0, 1'b0, mk(OP_LW), 32'h10, 32'h0);
        check_val("lw_merged", bus.mem_read_data_out, 32'hBEEF_AB78);
        cyc(1'b0, 1'b0, 1'b0, mk(OP_LB), 32'h11, 32'h0);
        check_val("lb11", bus.mem_read_data_out, 32'hFFFF_FFAB);
        cyc(1'b0, 1'b0, 1'b0, mk(OP_LBU), 32'h11, 32'h0);
        check_val("lbu11", bus.mem_read_data_out, 32'h0000_00AB);
        cyc(1'b0, 1'b0, 1'b0, mk(OP_LH), 32'h12, 32'h0);
        check_val("lh12", bus.mem_read_data_out, 32'hFFFF_BEEF);
        cyc(1'b0, 1'b0, 1'b0, mk(OP_LHU), 32'h12, 32'h0);
        check_val("lhu12", bus.mem_read_data_out, 32'h0000_BEEF);

        // misalignment
        cyc(1'b0, 1'b0, 1'b0, mk(OP_SW), 32'h13, 32'h0);
        check_val("mis_sw_err", 32'(bus.addr_err), 32'h1);
        check_val("mis_sw_we", 32'(bus.dm_we), 32'h0);
        cyc(1'b0, 1'b0, 1'b0, mk(OP_LH), 32'h11, 32'h0);
        check_val("mis_lh_err", 32'(bus.addr_err), 32'h1);
        check_val("mis_lh_rd", bus.mem_read_data_out, 32'h0);
        cyc(1'b0, 1'b0, 1'b0, mk(OP_LW), 32'h10, 32'h0);
        check_val("mis_unchanged", bus.mem_read_data_out, 32'hBEEF_AB78);

        // stall holds, flush (even with stall) inserts a nop
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 1'b1, 1'b0, mk(OP_SB), 32'h30 + 32'(i), $urandom());
            check_val("stall_alu", bus.alu_result_out, 32'h10);
        end
        cyc(1'b0, 1'b1, 1'b1, mk(OP_SW), 32'h34, 32'h0);
        check_val("flush_instr", bus.instructure_out, 32'h0);

        // store squashed by flush never writes
        cyc(1'b0, 1'b0, 1'b1, mk(OP_SW), 32'h20, 32'hDEAD_BEEF);
        cyc(1'b0, 1'b0, 1'b0, mk(OP_LW), 32'h20, 32'h0);
        check_val("squash_lw", bus.mem_read_data_out, 32'h0);

        // store held by stall keeps dm_we high and writes once-effectively
        cyc(1'b0, 1'b0, 1'b0, mk(OP_SW), 32'h24, 32'h1122_3344);
        cyc(1'b0, 1'b1, 1'b0, mk(OP_LW), 32'h0, 32'h0);
        check_val("stall_we", 32'(bus.dm_we), 32'h1);
        cyc(1'b0, 1'b0, 1'b0, mk(OP_LW), 32'h24, 32'h0);
        check_val("stall_sw_lw", bus.mem_read_data_out, 32'h1122_3344);

        // address wrap
        cyc(1'b0, 1'b0, 1'b0, mk(OP_SW), 32'h4000, 32'hCAFE_F00D);
        cyc(1'b0, 1'b0, 1'b0, mk(OP_LW), 32'h0, 32'h0);
        check_val("wrap_lw", bus.mem_read_data_out, 32'hCAFE_F00D);

        // reset while a store sits in MEM
        cyc(1'b0, 1'b0, 1'b0, mk(OP_SW), 32'h28, 32'h0000_0077);
        cyc(1'b1, 1'b0, 1'b0, mk(OP_LW), 32'h28, 32'h0);
        cyc(1'b0, 1'b0, 1'b0, mk(OP_LW), 32'h28, 32'h0);
        check_val("rst_store_lw", bus.mem_read_data_out, 32'h0);

        // randomized traffic over a small address window with wrap aliases
        for (int n = 0; n < 600; n++) begin
            r = $urandom_range(0, 99);
            k = $urandom_range(0, 9);
            ins = (k < 8) ? mk(ops[k]) : $urandom();
            adr = 32'($urandom_range(0, 63));
            if ($urandom_range(0, 3) == 0) adr = adr | ($urandom() & 32'hFFFF_C000);
            cyc(r < 2, (r >= 2) && (r < 12), (r >= 12) && (r < 17), ins, adr, $urandom());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- MEM stage of the 5-stage MIPS pipeline, directly downstream of EX.
- Contains the EX/MEM pipeline register with stall and flush control, plus the word-organised data memory.
- Performs lw/lh/lhu/lb/lbu loads and sw/sh/sb stores; detects misaligned accesses.
- Drives the MEM-stage forwarding value back to EX and the stage results on to the MEM/WB register.

Parameters:
- DM_WORDS, 4096, data memory depth in 32-bit words; power of two.
- DM_AW, 12, word-address width, equal to log2(DM_WORDS).

Ports:
- clk  in  1  pipeline clock, rising edge.
- reset  in  1  synchronous, active-high.
- stall  in  1  hold the EX/MEM register.
- flush  in  1  load a bubble into the EX/MEM register.
- pc_in  in  32  PC from EX.
- instructure_in  in  32  instruction word from EX.
- instr_code_in  in  6  decoded instruction code from EX.
- alu_result_in  in  32  EX result (effective address, ALU value or PC+8).
- reg_read_data2_in  in  32  forwarded rt value; store data.
- pc_out  out  32  latched PC.
- instructure_out  out  32  latched instruction.
- instr_code_out  out  6  latched instruction code.
- alu_result_out  out  32  latched EX result.
- mem_read_data_out  out  32  load data after extension.
- forward_data_MEM  out  32  equals alu_result_out.
- addr_err  out  1  current MEM instruction is a misaligned load or store.
- dm_we  out  1  a store commits at the next edge (bench observation).
- dm_addr  out  32  byte address of the access, word-aligned ({alu_result[31:2],2'b00}).
- dm_wdata  out  32  full merged word being written.

Behaviour:
- EX/MEM register, priority reset > flush > stall > capture, evaluated at the rising edge of clk:
  - reset or flush: all latched fields become 0. Instruction 0 is sll $0 = nop.
  - stall: all latched fields hold their value.
  - otherwise: all *_in values are captured.
- Reset values: every output is 0, including addr_err, dm_we and mem_read_data_out.
- All outputs are combinational from the latched fields and the memory; there is no further latency.
- Access decode uses the latched instructure[31:26]:
  - Loads: 0x23 lw, 0x21 lh, 0x25 lhu, 0x20 lb, 0x24 lbu.
  - Stores: 0x2B sw, 0x29 sh, 0x28 sb.
  - Any other opcode is no memory access.
- Address handling:
  - word index = alu_result[DM_AW+1:2]; upper bits are ignored, so the address wraps modulo the memory size.
  - byte lane = alu_result[1:0].
- Misalignment:
  - lw/sw with lane != 0 is misaligned.
  - lh/lhu/sh with lane[0] = 1 is misaligned.
  - Misaligned access raises addr_err, suppresses the write (dm_we = 0), and forces mem_read_data_out = 0.
- Loads, read combinationally from the addressed word W:
  - lw returns W.
  - lb/lbu select byte W[8*lane+7 : 8*lane].
  - lh/lhu select halfword W[16*lane[1]+15 : 16*lane[1]].
  - lb/lh sign-extend; lbu/lhu zero-extend.
  - Non-load instructions output 0.
- Stores:
  - An aligned store asserts dm_we; the merged word is written at the next rising edge.
  - sw writes all 4 bytes; sh writes the selected halfword from rt[15:0]; sb writes the selected byte from rt[7:0]. Other bytes keep their old value.
  - dm_wdata is the merged word.
- Stall interaction: a store held in MEM by stall rewrites the same value each cycle (idempotent). dm_we stays high while the store is held.
- Reset: memory contents are cleared to 0, synchronously, across all DM_WORDS. Reset at any point discards the in-flight instruction with no write.
- Simultaneous reset and store: reset wins; no write occurs.
- Forwarding: forward_data_MEM = alu_result_out. Load data is not forwarded from MEM; the hazard unit stalls load-use.
- Read-after-write: a load in the cycle after a store to the same word returns the new data.

Test Plan:
- Reset: assert reset for 2 cycles, then read lw from 0x0 -> all outputs 0, mem_read_data_out = 0.
- Word store then load: sw rt = 0x12345678 at address 0x10, then lw 0x10 -> dm_we = 1 and dm_wdata = 0x12345678 in the store cycle; load returns 0x12345678.
- Byte and halfword merge:
  - Start from word 0x10 = 0x12345678.
  - sb rt = 0xAB at 0x11 -> word becomes 0x1234AB78.
  - sh rt = 0xBEEF at 0x12 -> word becomes 0xBEEFAB78.
  - lb 0x11 -> 0xFFFFFFAB; lbu 0x11 -> 0x000000AB.
  - lh 0x12 -> 0xFFFFBEEF; lhu 0x12 -> 0x0000BEEF.
- Misalignment: sw to 0x13, then lh from 0x11 -> addr_err = 1 and dm_we = 0 for each; memory is unchanged; mem_read_data_out = 0.
- Stall and flush:
  - stall for 3 cycles with different *_in values -> outputs hold.
  - flush with stall also high -> outputs become 0 (nop).
  - A pending sw is squashed with no write.
- Address wrap: with DM_WORDS = 4096, sw to 0x4000 then lw from 0x0 -> returns the stored value.
